// File: rtl/dta_monitor_protocol_mc_if.sv
// Bundle of the monitored req/resp/data stream triplet.
// Latency: none, wires only.
// Backpressure: carried as-is; the monitor side only observes tready/tvalid.
interface dta_monitor_protocol_mc_if #(
  parameter int DATA_WIDTH = 512
);
  logic                  req_tvalid;
  logic                  req_tready;
  logic [63:0]           req_tdata;
  logic                  resp_tvalid;
  logic                  resp_tready;
  logic [63:0]           resp_tdata;
  logic                  data_tvalid;
  logic                  data_tready;
  logic [DATA_WIDTH-1:0] data_tdata;

  // Side that drives the streams (producer and consumer of the port)
  modport master (
    output req_tvalid, req_tready, req_tdata,
    output resp_tvalid, resp_tready, resp_tdata,
    output data_tvalid, data_tready, data_tdata
  );

  // Passive monitor side: everything is an input
  modport slave (
    input req_tvalid, req_tready, req_tdata,
    input resp_tvalid, resp_tready, resp_tdata,
    input data_tvalid, data_tready, data_tdata
  );
endinterface

// File: rtl/dta_monitor_protocol_mc.sv
// Passive protocol checker for one req/resp/data stream triplet of a direct-transfer adaptor port.
// Latency: flags registered 1 cycle after the offending handshake, sticky accumulator 1 cycle later.
// Backpressure: none exerted; handshakes are only observed, nothing is driven onto the buses.
module dta_monitor_protocol_mc #(
  parameter int DATA_WIDTH  = 512,
  parameter int CHANNEL_NUM = 32,
  parameter int REQ_DEPTH   = 16,
  parameter int RESP_DEPTH  = 16,
  parameter int MAX_BURST   = 32768,
  localparam int REQ_LVL_W  = $clog2(REQ_DEPTH + 1),
  localparam int RESP_LVL_W = $clog2(RESP_DEPTH + 1)
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst,
  dta_monitor_protocol_mc_if.slave mon,
  input  logic                   err_clear,
  output logic [15:0]            protocol_error,
  output logic                   protocol_error_ap_vld,
  output logic [15:0]            protocol_error_sticky,
  output logic [REQ_LVL_W-1:0]   req_level,
  output logic [RESP_LVL_W-1:0]  resp_level
);

  localparam int BYTES       = DATA_WIDTH / 8;
  localparam int BYTE_SHIFT  = $clog2(BYTES);
  localparam int REQ_PTR_W   = $clog2(REQ_DEPTH);
  localparam int RESP_PTR_W  = $clog2(RESP_DEPTH);

  // Limits widened to 17 bits so a 16-bit field can never wrap past them
  localparam logic [16:0] CH_LIMIT    = 17'(CHANNEL_NUM);
  localparam logic [16:0] BURST_LIMIT = 17'(MAX_BURST);
  localparam logic [16:0] BYTE_ROUND  = 17'(BYTES - 1);

  localparam logic [REQ_LVL_W-1:0]  REQ_FULL_LVL  = REQ_LVL_W'(REQ_DEPTH);
  localparam logic [RESP_LVL_W-1:0] RESP_FULL_LVL = RESP_LVL_W'(RESP_DEPTH);

  // Only the fields the checks care about are kept in the request queue
  typedef struct packed {
    logic [15:0] channel;
    logic        sof;
    logic        eof;
    logic [15:0] len;
  } desc_t;

  function automatic desc_t unpack_desc(input logic [63:0] d);
    desc_t r;
    r.channel = d[15:0];
    r.sof     = d[40];
    r.eof     = d[41];
    r.len     = d[63:48];
    return r;
  endfunction

  // Handshakes and decoded descriptors
  logic  req_hs, resp_hs, data_hs;
  desc_t req_desc, resp_desc, req_head;

  // Request queue
  desc_t                 req_mem [REQ_DEPTH];
  logic [REQ_PTR_W-1:0]  req_wr_ptr, req_rd_ptr;
  logic [REQ_LVL_W-1:0]  req_cnt;
  logic                  req_empty, req_full;
  logic                  req_push, req_pop;

  // Response queue holds the beat count each accepted response expects
  logic [16:0]           resp_mem [RESP_DEPTH];
  logic [RESP_PTR_W-1:0] resp_wr_ptr, resp_rd_ptr;
  logic [RESP_LVL_W-1:0] resp_cnt;
  logic                  resp_empty, resp_full;
  logic                  resp_push, resp_pop;
  logic [16:0]           resp_beats, resp_head_beats;

  // Beats already consumed from the head response
  logic [16:0]           beat_cnt, beat_cnt_next;

  // Per-source flag contributions
  logic [15:0]           req_flags, resp_flags, data_flags, err_next;

  assign req_hs  = mon.req_tvalid  & mon.req_tready;
  assign resp_hs = mon.resp_tvalid & mon.resp_tready;
  assign data_hs = mon.data_tvalid & mon.data_tready;

  assign req_desc  = unpack_desc(mon.req_tdata);
  assign resp_desc = unpack_desc(mon.resp_tdata);

  assign req_empty  = (req_cnt == '0);
  assign req_full   = (req_cnt == REQ_FULL_LVL);
  assign resp_empty = (resp_cnt == '0);
  assign resp_full  = (resp_cnt == RESP_FULL_LVL);

  assign req_head        = req_mem[req_rd_ptr];
  assign resp_head_beats = resp_mem[resp_rd_ptr];

  // Ceiling division of the response length by the bus width in bytes
  assign resp_beats = ({1'b0, resp_desc.len} + BYTE_ROUND) >> BYTE_SHIFT;

  // Ignored descriptor bits and the payload are folded here so nothing dangles
  logic unused_bits;
  assign unused_bits = ^{mon.req_tdata[47:42], mon.req_tdata[39:16],
                         mon.resp_tdata[47:42], mon.resp_tdata[39:16],
                         mon.data_tdata};

  // Request-side checks; malformed requests are still queued so responses stay aligned
  always_comb begin
    req_flags = '0;
    req_push  = 1'b0;
    if (req_hs) begin
      if (req_desc.len == 16'd0)                  req_flags[12] = 1'b1;
      if ({1'b0, req_desc.len} > BURST_LIMIT)     req_flags[8]  = 1'b1;
      if ({1'b0, req_desc.channel} >= CH_LIMIT)   req_flags[9]  = 1'b1;
      // Fullness is judged at start of cycle, so a same-cycle pop does not make room
      if (req_full) req_flags[6] = 1'b1;
      else          req_push     = 1'b1;
    end
  end

  // Response-side checks against the head request; the head is always popped to resync
  always_comb begin
    resp_flags = '0;
    req_pop    = 1'b0;
    resp_push  = 1'b0;
    if (resp_hs) begin
      if (req_empty) begin
        resp_flags[4] = 1'b1;
      end else begin
        req_pop = 1'b1;
        if (resp_desc.channel != req_head.channel) resp_flags[0] = 1'b1;
        if (resp_desc.sof != req_head.sof)         resp_flags[2] = 1'b1;
        if (resp_desc.eof != req_head.eof)         resp_flags[3] = 1'b1;
        if (resp_desc.len > req_head.len)          resp_flags[1] = 1'b1;
        if (resp_desc.len != 16'd0) begin
          if (resp_desc.len != req_head.len) resp_flags[13] = 1'b1;
          if (resp_full) resp_flags[7] = 1'b1;
          else           resp_push     = 1'b1;
        end
      end
    end
  end

  // Data-side accounting; a response accepted this same cycle cannot absorb a beat yet
  always_comb begin
    data_flags    = '0;
    resp_pop      = 1'b0;
    beat_cnt_next = beat_cnt;
    if (data_hs) begin
      if (resp_empty) begin
        data_flags[5] = 1'b1;
      end else if ((beat_cnt + 17'd1) == resp_head_beats) begin
        resp_pop      = 1'b1;
        beat_cnt_next = '0;
      end else begin
        beat_cnt_next = beat_cnt + 17'd1;
      end
    end
  end

  // Merge flags; reserved bits are forced low
  always_comb begin
    err_next     = req_flags | resp_flags | data_flags;
    err_next[10] = 1'b0;
    err_next[11] = 1'b0;
    err_next[14] = 1'b0;
    err_next[15] = 1'b0;
  end

  // Request queue pointers and occupancy
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      req_wr_ptr <= '0;
      req_rd_ptr <= '0;
      req_cnt    <= '0;
    end else begin
      if (req_push) req_wr_ptr <= req_wr_ptr + 1'b1;
      if (req_pop)  req_rd_ptr <= req_rd_ptr + 1'b1;
      case ({req_push, req_pop})
        2'b10:   req_cnt <= req_cnt + 1'b1;
        2'b01:   req_cnt <= req_cnt - 1'b1;
        default: req_cnt <= req_cnt;
      endcase
    end
  end

  // Request storage; occupancy gates every read so it needs no reset
  always_ff @(posedge ap_clk) begin
    if (req_push) req_mem[req_wr_ptr] <= req_desc;
  end

  // Response queue pointers and occupancy
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      resp_wr_ptr <= '0;
      resp_rd_ptr <= '0;
      resp_cnt    <= '0;
    end else begin
      if (resp_push) resp_wr_ptr <= resp_wr_ptr + 1'b1;
      if (resp_pop)  resp_rd_ptr <= resp_rd_ptr + 1'b1;
      case ({resp_push, resp_pop})
        2'b10:   resp_cnt <= resp_cnt + 1'b1;
        2'b01:   resp_cnt <= resp_cnt - 1'b1;
        default: resp_cnt <= resp_cnt;
      endcase
    end
  end

  // Response beat-count storage
  always_ff @(posedge ap_clk) begin
    if (resp_push) resp_mem[resp_wr_ptr] <= resp_beats;
  end

  // Beat counter for the head response
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) beat_cnt <= '0;
    else        beat_cnt <= beat_cnt_next;
  end

  // Registered flags, valid strobe and sticky accumulator
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      protocol_error        <= '0;
      protocol_error_ap_vld <= 1'b0;
      protocol_error_sticky <= '0;
    end else begin
      protocol_error        <= err_next;
      protocol_error_ap_vld <= (err_next != 16'd0);
      protocol_error_sticky <= (err_clear ? 16'd0 : protocol_error_sticky) | protocol_error;
    end
  end

  assign req_level  = req_cnt;
  assign resp_level = resp_cnt;

endmodule

// File: tb/tb_dta_monitor_protocol_mc.sv
// Bench for dta_monitor_protocol_mc: directed steps then random traffic against a queue-based model.
// Latency: model flags are compared one cycle after the stimulus cycle, sticky one cycle later.
// Backpressure: random tready on every stream.
module tb_dta_monitor_protocol_mc;
  localparam int DW    = 512;
  localparam int BYTES = DW / 8;
  localparam int CHN   = 32;
  localparam int RD    = 16;
  localparam int SD    = 16;
  localparam int MAXB  = 32768;

  logic        ap_clk = 1'b0;
  logic        ap_rst;
  logic        err_clear;
  logic [15:0] protocol_error;
  logic        protocol_error_ap_vld;
  logic [15:0] protocol_error_sticky;
  logic [4:0]  req_level;
  logic [4:0]  resp_level;

  dta_monitor_protocol_mc_if #(.DATA_WIDTH(DW)) bus ();

  dta_monitor_protocol_mc #(
    .DATA_WIDTH(DW), .CHANNEL_NUM(CHN), .REQ_DEPTH(RD), .RESP_DEPTH(SD), .MAX_BURST(MAXB)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .mon(bus),
    .err_clear(err_clear),
    .protocol_error(protocol_error),
    .protocol_error_ap_vld(protocol_error_ap_vld),
    .protocol_error_sticky(protocol_error_sticky),
    .req_level(req_level),
    .resp_level(resp_level)
  );

  always #5 ap_clk = ~ap_clk;

  // Reference model: outstanding requests and remaining beats per accepted response
  typedef struct {
    int ch;
    bit sof;
    bit eof;
    int len;
  } rq_t;

  rq_t         rq[$];
  int          sq[$];
  logic [15:0] m_err;
  logic [15:0] m_sticky;
  int          checks;
  int          failures;
  string       step;

  function automatic logic [63:0] desc(int ch, bit sof, bit eof, int len);
    logic [63:0] d;
    d        = '0;
    d[39:16] = 24'($urandom);
    d[47:42] = 6'($urandom);
    d[15:0]  = ch[15:0];
    d[40]    = sof;
    d[41]    = eof;
    d[63:48] = len[15:0];
    return d;
  endfunction

  task automatic check(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s/%s got=%h exp=%h", step, tag, got, exp);
    end
  endtask

  task automatic check_all();
    check("err", protocol_error, m_err);
    check("vld", {15'd0, protocol_error_ap_vld}, {15'd0, m_err != 16'd0});
    check("sticky", protocol_error_sticky, m_sticky);
    check("req_level", {11'd0, req_level}, 16'(rq.size()));
    check("resp_level", {11'd0, resp_level}, 16'(sq.size()));
  endtask

  task automatic idle();
    bus.req_tvalid  = 1'b0; bus.req_tready  = 1'b0; bus.req_tdata  = '0;
    bus.resp_tvalid = 1'b0; bus.resp_tready = 1'b0; bus.resp_tdata = '0;
    bus.data_tvalid = 1'b0; bus.data_tready = 1'b0; bus.data_tdata = '0;
    err_clear = 1'b0;
  endtask

  // One clock of stimulus, model update from start-of-cycle occupancy, then full check
  task automatic cycle(bit qv, bit qr, logic [63:0] qd,
                       bit sv, bit sr, logic [63:0] sd,
                       bit dv, bit dr, bit clr);
    logic [15:0] f;
    int rqn, sqn, qch, qlen, sch, slen, new_beats;
    bit push_sq;
    rq_t h, n;
    bus.req_tvalid  = qv; bus.req_tready  = qr; bus.req_tdata  = qd;
    bus.resp_tvalid = sv; bus.resp_tready = sr; bus.resp_tdata = sd;
    bus.data_tvalid = dv; bus.data_tready = dr;
    bus.data_tdata  = {16{$urandom}};
    err_clear = clr;

    f = '0; rqn = rq.size(); sqn = sq.size(); push_sq = 0; new_beats = 0;
    qch = int'(qd[15:0]); qlen = int'(qd[63:48]);
    sch = int'(sd[15:0]); slen = int'(sd[63:48]);
    if (qv && qr) begin
      if (qlen == 0)    f[12] = 1'b1;
      if (qlen > MAXB)  f[8]  = 1'b1;
      if (qch >= CHN)   f[9]  = 1'b1;
      if (rqn == RD)    f[6]  = 1'b1;
    end
    if (sv && sr) begin
      if (rqn == 0) f[4] = 1'b1;
      else begin
        h = rq.pop_front();
        if (sch != h.ch)        f[0] = 1'b1;
        if (sd[40] != h.sof)    f[2] = 1'b1;
        if (sd[41] != h.eof)    f[3] = 1'b1;
        if (slen > h.len)       f[1] = 1'b1;
        if (slen != 0 && slen != h.len) f[13] = 1'b1;
        if (slen != 0) begin
          if (sqn == SD) f[7] = 1'b1;
          else begin push_sq = 1; new_beats = (slen + BYTES - 1) / BYTES; end
        end
      end
    end
    if (dv && dr) begin
      if (sqn == 0) f[5] = 1'b1;
      else begin
        sq[0] = sq[0] - 1;
        if (sq[0] == 0) void'(sq.pop_front());
      end
    end
    if (push_sq) sq.push_back(new_beats);
    if (qv && qr && rqn < RD) begin
      n.ch = qch; n.sof = qd[40]; n.eof = qd[41]; n.len = qlen;
      rq.push_back(n);
    end

    @(posedge ap_clk); #1;
    m_sticky = (clr ? 16'd0 : m_sticky) | m_err;
    m_err    = f;
    check_all();
  endtask

  task automatic req_only(logic [63:0] d);
    cycle(1, 1, d, 0, 0, '0, 0, 0, 0);
  endtask
  task automatic resp_only(logic [63:0] d);
    cycle(0, 0, '0, 1, 1, d, 0, 0, 0);
  endtask
  task automatic data_only();
    cycle(0, 0, '0, 0, 0, '0, 1, 1, 0);
  endtask
  task automatic nop(bit clr);
    cycle(0, 0, '0, 0, 0, '0, 0, 0, clr);
  endtask

  // Hard stop if the run ever stalls
  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    checks = 0; failures = 0;
    m_err = '0; m_sticky = '0;
    idle();
    ap_rst = 1'b1;
    step = "reset";
    repeat (2) @(posedge ap_clk);
    #1;
    check_all();
    ap_rst = 1'b0;

    // Clean transfer: ch3 len128, matching resp, two 64-byte beats
    step = "clean";
    req_only(desc(3, 1, 1, 128));
    resp_only(desc(3, 1, 1, 128));
    check("resp_level_1", {11'd0, resp_level}, 16'd1);
    data_only();
    data_only();
    nop(0);
    check("clean_err", protocol_error, 16'h0000);
    check("clean_lvl", {11'd0, req_level, resp_level}, 16'd0);

    // Response with no outstanding request, then sticky and clear
    step = "orphan_resp";
    resp_only(desc(1, 0, 0, 64));
    check("orphan_err", protocol_error, 16'h0010);
    nop(0);
    check("orphan_sticky", protocol_error_sticky, 16'h0010);
    nop(1);
    check("cleared_sticky", protocol_error_sticky, 16'h0000);

    // Channel mismatch with overlong response length
    step = "mismatch";
    req_only(desc(5, 0, 1, 64));
    resp_only(desc(6, 0, 1, 128));
    check("mismatch_err", protocol_error, 16'h2003);
    data_only();
    data_only();
    nop(0);

    // Seventeen requests into a sixteen-deep queue
    step = "req_full";
    for (int i = 0; i < 17; i++) req_only(desc(1, 1, 1, 64));
    check("full_err", protocol_error, 16'h0040);
    check("full_level", {11'd0, req_level}, 16'd16);
    // Full queue with simultaneous pop: push still rejected, level drops by one
    cycle(1, 1, desc(1, 1, 1, 64), 1, 1, desc(1, 1, 1, 0), 0, 0, 0);
    check("full_pop_level", {11'd0, req_level}, 16'd15);
    // Drain with zero-length responses, which carry no data
    for (int i = 0; i < 15; i++) resp_only(desc(1, 1, 1, 0));
    nop(1);

    // Malformed requests
    step = "bad_req";
    req_only(desc(40, 0, 0, 0));
    check("len0_ch40", protocol_error, 16'h1200);
    req_only(desc(1, 0, 0, 40000));
    check("len40000", protocol_error, 16'h0100);
    resp_only(desc(40, 0, 0, 0));
    resp_only(desc(1, 0, 0, 0));
    nop(1);

    // Too many data beats, then data racing the first response
    step = "data_over";
    req_only(desc(2, 1, 0, 100));
    resp_only(desc(2, 1, 0, 100));
    data_only();
    data_only();
    data_only();
    check("extra_beat", protocol_error, 16'h0020);
    req_only(desc(2, 0, 0, 64));
    cycle(0, 0, '0, 1, 1, desc(2, 0, 0, 64), 1, 1, 0);
    check("race_beat", protocol_error, 16'h0020);
    data_only();
    // All three streams at once with both queues empty
    cycle(1, 1, desc(4, 1, 1, 64), 1, 1, desc(4, 1, 1, 64), 1, 1, 0);
    check("all_empty", protocol_error, 16'h0030);
    resp_only(desc(4, 1, 1, 64));
    nop(1);

    // Reset asserted mid-burst discards everything at once
    step = "mid_reset";
    req_only(desc(7, 1, 1, 256));
    req_only(desc(7, 1, 1, 256));
    resp_only(desc(7, 1, 1, 256));
    data_only();
    idle();
    #2 ap_rst = 1'b1;
    #1;
    rq.delete(); sq.delete(); m_err = '0; m_sticky = '0;
    check_all();
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    nop(0);
    nop(0);

    // Random traffic
    step = "random";
    for (int c = 0; c < 3000; c++) begin
      bit qv, qr, sv, sr, dv, dr, clr;
      int ch, len, sel;
      logic [63:0] qd, sd;
      qv = ($urandom_range(0, 99) < 35); qr = ($urandom_range(0, 99) < 80);
      sv = ($urandom_range(0, 99) < 35); sr = ($urandom_range(0, 99) < 80);
      dv = ($urandom_range(0, 99) < 70); dr = ($urandom_range(0, 99) < 80);
      clr = ($urandom_range(0, 99) < 5);
      ch = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 40) : $urandom_range(0, 7);
      sel = $urandom_range(0, 19);
      case (sel)
        0:       len = 0;
        1:       len = MAXB + $urandom_range(1, 3);
        2:       len = MAXB;
        default: len = $urandom_range(1, 300);
      endcase
      qd = desc(ch, $urandom_range(0, 1), $urandom_range(0, 1), len);
      if (rq.size() > 0 && $urandom_range(0, 99) < 70) begin
        len = ($urandom_range(0, 3) == 0) ? 0 : rq[0].len;
        if (len > 600) len = 0;
        sd = desc(rq[0].ch, rq[0].sof, rq[0].eof, len);
      end else begin
        sd = desc($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
                  $urandom_range(0, 300));
      end
      cycle(qv, qr, qd, sv, sr, sd, dv, dr, clr);
    end
    idle();
    nop(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dta_monitor_protocol_mc.md
# dta_monitor_protocol_mc

Parametrised passive protocol monitor for one req/resp/data stream triplet of a direct-transfer adaptor port (ingress or egress, receive or transmit side). It tracks up to REQ_DEPTH outstanding requests and up to RESP_DEPTH outstanding responses in order. It checks every response against its request and every data beat against the response stream. It reports per-cycle error flags, a sticky error accumulator, and live outstanding levels. It drives nothing on the monitored buses.

## Interface
Parameters:
- DATA_WIDTH, 512: data bus width in bits; DATA_WIDTH/8 (BYTES) is a power of two.
- CHANNEL_NUM, 32: number of valid channel indices.
- REQ_DEPTH, 16: outstanding request queue depth (power of two).
- RESP_DEPTH, 16: outstanding response queue depth (power of two).
- MAX_BURST, 32768: largest legal request burst_length in bytes.

Ports:
- ap_clk  in  1  single clock.
- ap_rst  in  1  reset, asynchronous, active-high.
- req_tready / req_tvalid  in  1  request handshake.
- req_tdata  in  64  request descriptor.
- resp_tready / resp_tvalid  in  1  response handshake.
- resp_tdata  in  64  response descriptor, same layout as request.
- data_tready / data_tvalid  in  1  data handshake.
- data_tdata  in  DATA_WIDTH  monitored only; contents not checked.
- err_clear  in  1  one-cycle pulse that clears protocol_error_sticky.
- protocol_error  out  16  per-cycle error flags, registered.
- protocol_error_ap_vld  out  1  high when protocol_error != 0.
- protocol_error_sticky  out  16  OR-accumulated flags since reset or clear.
- req_level  out  $clog2(REQ_DEPTH+1)  outstanding requests.
- resp_level  out  $clog2(RESP_DEPTH+1)  outstanding responses awaiting data.

## Operation
- Descriptor layout: [15:0] channel; [40] sof; [41] eof; [63:48] burst_length in bytes. All other bits are ignored.
- A handshake is tvalid & tready in the same cycle. Nothing else is considered.
- Req handshake checks:
  - burst_length == 0 → bit 12.
  - burst_length > MAX_BURST → bit 8.
  - channel >= CHANNEL_NUM → bit 9.
  - Queue full → bit 6, request dropped. Otherwise {channel, sof, eof, burst_length} is pushed, including when other checks fail.
- Resp handshake with req queue empty at start of cycle → bit 4. No pop, no push.
- Resp handshake otherwise: compare against the head entry, then always pop it (resync on error).
  - channel != head → bit 0.
  - sof != head → bit 2; eof != head → bit 3.
  - resp length > head length → bit 1.
  - resp length != 0 and != head length → bit 13.
  - resp length == 0 means no data. Nothing is pushed to the response queue.
  - resp length != 0: push beats = (L + BYTES-1) >> log2(BYTES), 17-bit arithmetic. If the response queue is full → bit 7 and no push.
- Data handshake with response queue empty at start of cycle → bit 5. A resp pushed in the same cycle does not count.
- Data handshake otherwise: decrement the remaining count of the head entry. When the count reaches 0, pop the entry.
- Bits 10, 11, 14, 15 are reserved and always 0.
- protocol_error_sticky: next = (err_clear ? 0 : sticky) | new flags. A flag arriving in the clear cycle survives.

## Timing
- Reset values: protocol_error = 0, protocol_error_ap_vld = 0, protocol_error_sticky = 0, req_level = 0, resp_level = 0. Both queues and the beat counter are emptied.
- Reset asserted mid-burst discards all state immediately. No flags are raised on deassert.
- Latency: a violating handshake in cycle N → protocol_error and protocol_error_ap_vld in cycle N+1 → sticky updated in cycle N+2.
- protocol_error_ap_vld is high for exactly the cycles where protocol_error is nonzero.
- Levels are registered and reflect pushes and pops from the previous edge.
- Same cycle, queue non-empty: push and pop of that queue both take effect and the level is unchanged.
- Same cycle, req queue empty: a resp with a simultaneous req flags bit 4, and the req is pushed.
- Full queue with simultaneous pop: the push is still rejected. Fullness is judged at the start of the cycle.
- Pointers wrap modulo depth.
- Every cycle can accept one req, one resp and one data beat.

## Test plan
- Req ch 3, len 128, sof=eof=1; then resp identical; then 2 data beats (BYTES=64) → protocol_error stays 0; levels return to 0.
- Resp with empty req queue → protocol_error = 0x0010 one cycle later; sticky = 0x0010; err_clear → sticky = 0.
- Req len 64; resp ch mismatch with len 128 → protocol_error = 0x2003.
- 17 reqs with REQ_DEPTH=16 and no resp → 17th flags 0x0040; req_level = 16.
- Req len 0 on ch 40 (CHANNEL_NUM=32) → 0x1200. Req len 40000 → 0x0100.
- Req len 100; resp len 100 (2 beats); 3 data beats → third beat flags 0x0020. Data in the same cycle as the first resp on an empty queue also flags 0x0020.
